// File: rtl/acc_alu_pkg.sv
// Shared encodings for the accumulator ALU: opcodes, controller states and
// the shift-amount width.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_NAND  = 4'd3,
        OP_OR    = 4'd4,
        OP_NOR   = 4'd5,
        OP_XOR   = 4'd6,
        OP_XNOR  = 4'd7,
        OP_SHL   = 4'd8,
        OP_SHR   = 4'd9,
        OP_MUL   = 4'd10,
        OP_DIV   = 4'd11,
        OP_MOD   = 4'd12,
        OP_PASSA = 4'd13
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } state_t;

    localparam int SHAMT_W = 6;

endpackage

// File: rtl/acc_alu_if.sv
// Request/response bundle of the accumulator ALU; the requester drives the
// master side, the ALU sits on the slave side.
interface acc_alu_if #(
    parameter int N = 16
) ();

    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         b_sel;
    logic         acc_we;
    logic         out_valid;
    logic [N-1:0] result;
    logic [N-1:0] acc;
    logic         carry;
    logic         zero;
    logic         dbz;

    modport master (
        output in_valid, op, a, b, b_sel, acc_we,
        input  in_ready, out_valid, result, acc, carry, zero, dbz
    );

    modport slave (
        input  in_valid, op, a, b, b_sel, acc_we,
        output in_ready, out_valid, result, acc, carry, zero, dbz
    );

endinterface

// File: rtl/acc_alu_seq_div.sv
// Restoring radix-2 unsigned divider. The first quotient bit is resolved on
// the start edge, so done pulses N-1 cycles later with final quotient/remainder.
module seq_div #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
);

    localparam int CNT_W = $clog2(N) + 1;

    logic [N-1:0]     rem_q;
    logic [N-1:0]     quo_q;
    logic [N-1:0]     dvs_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    function automatic logic [2*N-1:0] div_step(input logic [N-1:0] r,
                                                input logic [N-1:0] q,
                                                input logic [N-1:0] d);
        logic [N:0] sh;
        logic [N:0] diff;
        sh   = {r, q[N-1]};
        diff = sh - {1'b0, d};
        if (diff[N]) return {sh[N-1:0], q[N-2:0], 1'b0};
        else         return {diff[N-1:0], q[N-2:0], 1'b1};
    endfunction

    always_ff @(posedge clk) begin
        if (clr) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                busy_q <= 1'b1;
                cnt_q  <= CNT_W'(N - 1);
            end else if (busy_q) begin
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            {rem_q, quo_q} <= div_step('0, dividend, divisor);
            dvs_q          <= divisor;
        end else if (busy_q) begin
            {rem_q, quo_q} <= div_step(rem_q, quo_q, dvs_q);
        end
    end

    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/acc_alu.sv
// Accumulator ALU: single-cycle ops complete the cycle after acceptance,
// DIV/MOD with a nonzero divisor run on the iterative divider.
module acc_alu #(
    parameter int N = 16
) (
    input  logic     clk,
    input  logic     rst,
    acc_alu_if.slave bus
);
    import alu_pkg::*;

    state_t       state_q;
    state_t       state_d;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         carry_q;
    logic         zero_q;
    logic         dbz_q;
    logic [N-1:0] result_q;
    logic [N-1:0] acc_q;
    logic [3:0]   op_p0;
    logic         we_p0;

    logic         accept;
    logic         is_div_op;
    logic         div_start;
    logic         div_done;
    logic         calc_dbz;
    logic [N-1:0] b_eff;
    logic [N-1:0] quo;
    logic [N-1:0] rem;
    logic [N-1:0] div_res;
    logic [N:0]   calc;

    // Returns {carry, result} for every op that finishes in one cycle.
    function automatic logic [N:0] alu_calc(input logic [3:0]   op,
                                            input logic [N-1:0] x,
                                            input logic [N-1:0] y);
        logic [N:0]         wide;
        logic [SHAMT_W-1:0] sh;
        logic [N-1:0]       r;
        logic               c;
        wide = '0;
        sh   = SHAMT_W'(y);
        r    = '0;
        c    = 1'b0;
        case (op)
            OP_ADD: begin
                wide = {1'b0, x} + {1'b0, y};
                r    = wide[N-1:0];
                c    = wide[N];
            end
            OP_SUB: begin
                wide = {1'b0, x} - {1'b0, y};
                r    = wide[N-1:0];
                c    = ~wide[N];
            end
            OP_AND:   r = x & y;
            OP_NAND:  r = ~(x & y);
            OP_OR:    r = x | y;
            OP_NOR:   r = ~(x | y);
            OP_XOR:   r = x ^ y;
            OP_XNOR:  r = ~(x ^ y);
            OP_SHL:   r = (int'(sh) >= N) ? '0 : (x << sh);
            OP_SHR:   r = (int'(sh) >= N) ? '0 : (x >> sh);
            OP_MUL:   r = x * y;
            OP_DIV:   r = '1;
            OP_MOD:   r = x;
            OP_PASSA: r = x;
            default:  r = '0;
        endcase
        return {c, r};
    endfunction

    assign accept    = bus.in_valid & in_ready_q;
    assign b_eff     = bus.b_sel ? acc_q : bus.b;
    assign is_div_op = (bus.op == OP_DIV) || (bus.op == OP_MOD);
    assign calc_dbz  = is_div_op && (b_eff == '0);
    assign div_start = accept && is_div_op && !calc_dbz;
    assign calc      = alu_calc(bus.op, bus.a, b_eff);
    assign div_res   = (op_p0 == OP_MOD) ? rem : quo;

    seq_div #(.N(N)) u_div (
        .clk       (clk),
        .clr       (rst),
        .start     (div_start),
        .dividend  (bus.a),
        .divisor   (b_eff),
        .done      (div_done),
        .quotient  (quo),
        .remainder (rem)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (div_start) state_d = ST_DIV;
            ST_DIV:  if (div_done)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage p0: request capture / single-cycle completion / divider completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            acc_q       <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d == ST_IDLE);
            out_valid_q <= 1'b0;
            if (accept && !div_start) begin
                result_q    <= calc[N-1:0];
                carry_q     <= calc[N];
                zero_q      <= (calc[N-1:0] == '0);
                dbz_q       <= calc_dbz;
                out_valid_q <= 1'b1;
                if (bus.acc_we) acc_q <= calc[N-1:0];
            end else if (div_done) begin
                result_q    <= div_res;
                carry_q     <= 1'b0;
                zero_q      <= (div_res == '0);
                dbz_q       <= 1'b0;
                out_valid_q <= 1'b1;
                if (we_p0) acc_q <= div_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (div_start) begin
            op_p0 <= bus.op;
            we_p0 <= bus.acc_we;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.acc       = acc_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.dbz       = dbz_q;

endmodule

// File: doc/acc_alu.md
ACC_ALU -- requirements
Module: acc_alu

Interface
REQ-001 The module SHALL have parameter N, default 16, giving the operand, result and accumulator width (legal range 4..64).
REQ-002 The module SHALL have clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have rst, input, 1 bit, a synchronous active-high reset.
REQ-004 The module SHALL have in_valid, input, 1 bit, meaning a request is offered.
REQ-005 The module SHALL have in_ready, output, 1 bit, meaning a request can be accepted this cycle.
REQ-006 The module SHALL have op, input, 4 bits, the opcode.
REQ-007 The module SHALL have a and b, inputs, N bits each, the operands.
REQ-008 The module SHALL have b_sel, input, 1 bit, which selects acc instead of b as operand B when 1.
REQ-009 The module SHALL have acc_we, input, 1 bit, meaning the accumulator is written with this request's result.
REQ-010 The module SHALL have out_valid, output, 1 bit, a one-cycle pulse marking result as new.
REQ-011 The module SHALL have result, output, N bits, the registered result, held until the next completion.
REQ-012 The module SHALL have acc, output, N bits, the accumulator register.
REQ-013 The module SHALL have carry, zero and dbz, outputs, 1 bit each, the flags of the last completed operation.

Function
REQ-014 The opcodes SHALL be: 0 ADD, 1 SUB (A-B), 2 AND, 3 NAND, 4 OR, 5 NOR, 6 XOR, 7 XNOR, 8 SHL, 9 SHR (logical), 10 MUL (low N bits), 11 DIV (unsigned quotient), 12 MOD (unsigned remainder), 13 PASSA; opcodes 14-15 SHALL produce 0.
REQ-015 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1; operands, op, b_sel and acc_we SHALL be captured at acceptance.
REQ-016 The state machine SHALL have two states: IDLE (in_ready=1) and DIV (in_ready=0); IDLE SHALL go to DIV on accepting DIV or MOD with a nonzero divisor, and DIV SHALL return to IDLE after N iteration cycles.
REQ-017 Non-divide ops and divide-by-zero SHALL complete with latency 1: result, flags and out_valid SHALL be valid in the cycle after acceptance.
REQ-018 DIV and MOD with a nonzero divisor SHALL use a restoring radix-2 algorithm, one quotient bit per cycle, with out_valid in the cycle N+1 after acceptance; back-to-back single-cycle requests SHALL sustain one result per cycle.
REQ-019 Divide by zero SHALL give result all-ones for DIV, result A for MOD, and dbz=1; dbz SHALL be 0 for every other completion.
REQ-020 ADD and SUB SHALL compute in N+1 bits; carry SHALL be the carry-out for ADD and the NOT-borrow for SUB (1 when A>=B); carry SHALL be 0 for all other ops.
REQ-021 SHL and SHR SHALL use B[5:0] as the shift amount; amounts >= N SHALL yield 0.
REQ-022 zero SHALL be 1 exactly when the completed result is 0.
REQ-023 When acc_we was captured as 1, acc SHALL take the result in the same cycle out_valid is asserted; otherwise acc SHALL be unchanged.
REQ-024 When b_sel=1, the acc value at acceptance SHALL be used, including an acc written by the immediately preceding completion (no hazard stall).
REQ-025 in_valid during DIV SHALL be ignored and SHALL NOT be lost silently: the requester holds it until in_ready=1.

Reset
REQ-026 On rst=1 at a clock edge, state SHALL become IDLE, and result, acc, carry, zero, dbz and out_valid SHALL become 0; in_ready SHALL be 1 in the following cycle.
REQ-027 rst SHALL take priority over a simultaneous acceptance, and a reset during DIV SHALL abort the division with no out_valid and acc unchanged from its reset value.

Structure
REQ-028 The opcode encodings, state encoding and the shift-amount width constant SHALL live in shared package alu_pkg.
REQ-029 The iterative divider SHALL be a separate sub-module, seq_div, parametrised by N, with start/done handshake, quotient, remainder and a clear input driven by rst.
REQ-030 All outputs SHALL be registered, and no combinational path SHALL exist from in_valid to in_ready.

Verification
REQ-031 The bench SHALL check ADD, N=16: a=16'hFFFF, b=1 -> result 0, carry 1, zero 1, out_valid one cycle after acceptance.
REQ-032 The bench SHALL check SUB: a=5, b=7 -> result 16'hFFFE, carry 0; a=7, b=5 -> result 2, carry 1.
REQ-033 The bench SHALL check DIV: a=1000, b=7 -> in_ready 0 for 16 cycles, result 142 at cycle 17; the same operands with MOD -> result 6.
REQ-034 The bench SHALL check DIV by zero: a=9, b=0 -> result 16'hFFFF, dbz 1, latency 1, in_ready never dropping.
REQ-035 The bench SHALL check accumulator chaining: ADD a=3, b=0 with acc_we, then ADD a=4 with b_sel=1 and acc_we on consecutive cycles -> acc 3, then acc 7.
REQ-036 The bench SHALL check reset mid-DIV: rst at cycle 5 of a division -> no out_valid, all outputs 0, in_ready 1, and the next ADD completes normally.
